// File: rtl/dsp_file_engine_if.sv
// Request/response bundle between dsp_file_engine and the single-transfer bus master.
// The engine drives the request side; the bus master answers with active/data_rd.
interface dsp_file_engine_if #(
    parameter int unsigned dw = 32,
    parameter int unsigned aw = 32
);
    logic [aw-1:0] address;
    logic          start;
    logic [3:0]    selection;
    logic          write;
    logic [dw-1:0] data_wr;
    logic [dw-1:0] data_rd;
    logic          active;

    modport master (output address, start, selection, write, data_wr, input data_rd, active);
    modport slave  (input address, start, selection, write, data_wr, output data_rd, active);
endinterface

// File: rtl/dsp_file_engine.sv
// Circular-file engine: reads/writes one element of a RAM-resident file per request,
// fetching and updating its descriptor through the single-transfer bus master.
module dsp_file_engine #(
    parameter int unsigned    dw          = 32,
    parameter int unsigned    aw          = 32,
    parameter int unsigned    NUM_FILES   = 8,
    parameter logic [aw-1:0]  FILE_BASE   = 32'h0000_0000,
    parameter logic [aw-1:0]  DESC_STRIDE = 32'h0000_0020,
    parameter bit             CACHE_EN    = 1'b1
) (
    input  logic               wb_clk,
    input  logic               wb_rst_n,
    input  logic [7:0]         file_num,
    input  logic               file_read,
    input  logic               file_write,
    input  logic [dw-1:0]      file_write_data,
    output logic [dw-1:0]      file_read_data,
    output logic               file_busy,
    output logic               file_done,
    output logic               file_error,
    dsp_file_engine_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_DESC_RD, S_EVAL, S_DATA, S_WB_STATUS, S_WB_PTR, S_DONE
    } state_t;

    localparam logic [8:0] NF = 9'(NUM_FILES);

    state_t          state_r;
    logic [1:0]      bus_phase_r;
    logic [2:0]      desc_idx_r;
    logic [7:0]      fnum_r, cache_fnum_r;
    logic            rd_req_r, wr_req_r, err_r, cache_valid_r;
    logic [dw-1:0]   wdata_r, status_r, rdata_r;
    logic [aw-1:0]   start_ptr_r, end_ptr_r, rd_ptr_r, wr_ptr_r, op_ptr_r;
    logic [1:0]      control_r;
    logic            busy_r, done_r, error_r;
    logic [aw-1:0]   bus_addr_r;
    logic            bus_start_r, bus_write_r;
    logic [3:0]      bus_sel_r;
    logic [dw-1:0]   bus_data_r;

    logic [aw-1:0]   desc_base_s, inc_s, cur_ptr_s, sum_s, next_ptr_s;
    logic            wrap_s, bad_req_s, cache_hit_s, bus_state_s, bus_done_s;
    logic [3:0]      lane_sel_s, req_sel_s;
    logic [dw-1:0]   wr_lanes_s, rd_shift_s, rd_lane_s, req_data_s;
    logic [aw-1:0]   req_addr_s;
    logic            req_we_s;

    assign desc_base_s = FILE_BASE + DESC_STRIDE * aw'(fnum_r);
    assign bad_req_s   = ({1'b0, fnum_r} >= NF) || (rd_req_r && wr_req_r);
    assign cache_hit_s = CACHE_EN && cache_valid_r && (cache_fnum_r == fnum_r);
    assign bus_state_s = (state_r == S_DESC_RD) || (state_r == S_DATA) ||
                         (state_r == S_WB_STATUS) || (state_r == S_WB_PTR);
    assign bus_done_s  = (bus_phase_r == 2'd2) && !bus.active;
    assign cur_ptr_s   = wr_req_r ? wr_ptr_r : rd_ptr_r;
    assign sum_s       = cur_ptr_s + inc_s;
    assign wrap_s      = sum_s > end_ptr_r;
    assign next_ptr_s  = wrap_s ? start_ptr_r : sum_s;

    // Element increment from the descriptor size field
    always_comb begin
        inc_s = aw'(3'd0);
        case (control_r)
            2'd1:    inc_s = aw'(3'd1);
            2'd2:    inc_s = aw'(3'd2);
            2'd3:    inc_s = aw'(3'd4);
            default: inc_s = aw'(3'd0);
        endcase
    end

    // Byte-lane enables, replicated write data and right-justified read data
    always_comb begin
        lane_sel_s = 4'hF;
        wr_lanes_s = wdata_r;
        rd_shift_s = bus.data_rd >> {op_ptr_r[1:0], 3'b000};
        rd_lane_s  = rd_shift_s;
        case (control_r)
            2'd1: begin
                lane_sel_s = 4'b0001 << op_ptr_r[1:0];
                wr_lanes_s = {4{wdata_r[7:0]}};
                rd_lane_s  = {24'h00_0000, rd_shift_s[7:0]};
            end
            2'd2: begin
                lane_sel_s = op_ptr_r[1] ? 4'hC : 4'h3;
                wr_lanes_s = {2{wdata_r[15:0]}};
                rd_lane_s  = {16'h0000, rd_shift_s[15:0]};
            end
            default: begin
                lane_sel_s = 4'hF;
            end
        endcase
    end

    // Bus request contents for whichever bus-owning state is active
    always_comb begin
        req_addr_s = {aw{1'b0}};
        req_we_s   = 1'b0;
        req_sel_s  = 4'hF;
        req_data_s = {dw{1'b0}};
        case (state_r)
            S_DESC_RD: req_addr_s = desc_base_s + aw'({desc_idx_r, 2'b00});
            S_DATA: begin
                req_addr_s = {op_ptr_r[aw-1:2], 2'b00};
                req_we_s   = wr_req_r;
                req_sel_s  = lane_sel_s;
                req_data_s = wr_req_r ? wr_lanes_s : {dw{1'b0}};
            end
            S_WB_STATUS: begin
                req_addr_s = desc_base_s + aw'(5'h10);
                req_we_s   = 1'b1;
                req_data_s = status_r;
            end
            S_WB_PTR: begin
                req_addr_s = desc_base_s + (wr_req_r ? aw'(5'h0C) : aw'(5'h08));
                req_we_s   = 1'b1;
                req_data_s = wr_req_r ? wr_ptr_r : rd_ptr_r;
            end
            default: req_addr_s = {aw{1'b0}};
        endcase
    end

    // Request sequencer, descriptor cache and bus handshake
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_r <= S_IDLE;       bus_phase_r <= 2'd0;    desc_idx_r <= 3'd0;
            fnum_r <= 8'd0;          cache_fnum_r <= 8'd0;   cache_valid_r <= 1'b0;
            rd_req_r <= 1'b0;        wr_req_r <= 1'b0;       err_r <= 1'b0;
            wdata_r <= {dw{1'b0}};   status_r <= {dw{1'b0}}; rdata_r <= {dw{1'b0}};
            start_ptr_r <= {aw{1'b0}}; end_ptr_r <= {aw{1'b0}};
            rd_ptr_r <= {aw{1'b0}};  wr_ptr_r <= {aw{1'b0}}; op_ptr_r <= {aw{1'b0}};
            control_r <= 2'd0;       busy_r <= 1'b0;         done_r <= 1'b0;
            error_r <= 1'b0;         bus_addr_r <= {aw{1'b0}}; bus_start_r <= 1'b0;
            bus_write_r <= 1'b0;     bus_sel_r <= 4'h0;      bus_data_r <= {dw{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (file_read || file_write) begin
                        fnum_r   <= file_num;
                        rd_req_r <= file_read;
                        wr_req_r <= file_write;
                        wdata_r  <= file_write_data;
                        err_r    <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad_req_s) begin
                        err_r <= 1'b1; cache_valid_r <= 1'b0;
                        done_r <= 1'b1; error_r <= 1'b1; state_r <= S_DONE;
                    end else if (cache_hit_s) begin
                        state_r <= S_EVAL;
                    end else begin
                        desc_idx_r <= 3'd0; bus_phase_r <= 2'd0; state_r <= S_DESC_RD;
                    end
                end
                S_DESC_RD: begin
                    if (bus_done_s) begin
                        case (desc_idx_r)
                            3'd0:    start_ptr_r <= bus.data_rd;
                            3'd1:    end_ptr_r   <= bus.data_rd;
                            3'd2:    rd_ptr_r    <= bus.data_rd;
                            3'd3:    wr_ptr_r    <= bus.data_rd;
                            3'd4:    status_r    <= bus.data_rd;
                            default: control_r   <= bus.data_rd[1:0];
                        endcase
                        bus_phase_r <= 2'd0;
                        if (desc_idx_r == 3'd5) state_r <= S_EVAL;
                        else desc_idx_r <= desc_idx_r + 3'd1;
                    end
                end
                S_EVAL: begin
                    bus_phase_r <= 2'd0;
                    if (control_r == 2'd0) begin
                        err_r <= 1'b1; status_r[3] <= 1'b1; state_r <= S_WB_STATUS;
                    end else if (rd_req_r && (rd_ptr_r == wr_ptr_r)) begin
                        err_r <= 1'b1; status_r[1] <= 1'b1; status_r[3] <= 1'b1; state_r <= S_WB_STATUS;
                    end else if (wr_req_r && (next_ptr_s == rd_ptr_r)) begin
                        err_r <= 1'b1; status_r[2] <= 1'b1; status_r[3] <= 1'b1; state_r <= S_WB_STATUS;
                    end else begin
                        op_ptr_r <= cur_ptr_s;
                        if (wr_req_r) wr_ptr_r <= next_ptr_s;
                        else rd_ptr_r <= next_ptr_s;
                        status_r[2:1] <= 2'b00;
                        if (wrap_s) status_r[0] <= 1'b1;
                        state_r <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus_done_s) begin
                        if (rd_req_r) rdata_r <= rd_lane_s;
                        bus_phase_r <= 2'd0;
                        state_r <= S_WB_STATUS;
                    end
                end
                S_WB_STATUS: begin
                    if (bus_done_s) begin
                        bus_phase_r <= 2'd0;
                        if (err_r) begin
                            cache_valid_r <= 1'b0; done_r <= 1'b1; error_r <= 1'b1; state_r <= S_DONE;
                        end else begin
                            state_r <= S_WB_PTR;
                        end
                    end
                end
                S_WB_PTR: begin
                    if (bus_done_s) begin
                        bus_phase_r <= 2'd0;
                        cache_valid_r <= CACHE_EN;
                        cache_fnum_r <= fnum_r;
                        done_r <= 1'b1;
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0; error_r <= 1'b0; busy_r <= 1'b0; state_r <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
            // Phase 0 launches, 1 holds start until active, 2 waits for active to drop
            if (bus_state_s) begin
                case (bus_phase_r)
                    2'd0: begin
                        bus_addr_r <= req_addr_s; bus_write_r <= req_we_s;
                        bus_sel_r <= req_sel_s;   bus_data_r <= req_data_s;
                        bus_start_r <= 1'b1;      bus_phase_r <= 2'd1;
                    end
                    2'd1: begin
                        if (bus.active) begin
                            bus_start_r <= 1'b0; bus_write_r <= 1'b0; bus_phase_r <= 2'd2;
                        end
                    end
                    default: bus_start_r <= 1'b0;
                endcase
            end
        end
    end

    assign file_read_data = rdata_r;
    assign file_busy      = busy_r;
    assign file_done      = done_r;
    assign file_error     = error_r;
    assign bus.address    = bus_addr_r;
    assign bus.start      = bus_start_r;
    assign bus.selection  = bus_sel_r;
    assign bus.write      = bus_write_r;
    assign bus.data_wr    = bus_data_r;
endmodule
